// File: rtl/block_data_memory.sv
// block_data_memory: 64 x 32-bit block store behind a fixed-latency
// request/busywait handshake. It is meant to sit below a cache.
//
// Handshake: the requester raises exactly one of read/write together with
// address (and writedata for writes). busywait rises combinationally in
// that same cycle. The request is latched on the next rising edge, and
// later changes on the inputs have no effect. busywait stays high for the
// whole access and drops in the single DONE cycle. For a read, readdata is
// valid from that DONE cycle until the next read completes. If both read
// and write are high, the pair is treated as no request.
//
// Optional build macro:
//   DMEM_CLEAR_ON_RESET_EN - when defined, every reset edge also zeroes all
//                            64 blocks. When undefined, block contents
//                            survive reset.
module block_data_memory #(
  parameter int LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        op_write;
  logic [5:0]  lat_addr;
  logic [31:0] lat_data;
  logic [31:0] mem [64];

  logic req_one;
  logic complete;

  // The request is legal only when exactly one of read/write is high.
  assign req_one  = read ^ write;
  // The access finishes on the edge where the latency counter reaches zero.
  assign complete = (state == ACCESS) && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: in DONE, read/write are ignored for one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_one) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: busywait is raised in the cycle the request appears.
  always_comb begin
    busywait  = 1'b0;
    fsm_state = state;
    if ((state == IDLE && req_one) || state == ACCESS) begin
      busywait = 1'b1;
    end
  end

  // Latch the request on acceptance and count down the latency.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= 4'd0;
      op_write <= 1'b0;
      lat_addr <= 6'd0;
      lat_data <= 32'd0;
    end else if (state == IDLE && req_one) begin
      cnt      <= 4'(LATENCY - 1);
      op_write <= write;
      lat_addr <= address;
      lat_data <= writedata;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Read data register: loaded only when a read completes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      readdata <= 32'd0;
    end else if (complete && !op_write) begin
      readdata <= mem[lat_addr];
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  // Block array: cleared by reset, written when a write access completes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (complete && op_write) begin
      mem[lat_addr] <= lat_data;
    end
  end
`else
  // Block array: kept across reset. A reset edge still blocks the commit,
  // so an access cut short by reset leaves the array untouched.
  always_ff @(posedge clock) begin
    if (reset && complete && op_write) begin
      mem[lat_addr] <= lat_data;
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: directed vectors for block_data_memory at
// LATENCY=5. The block is built with or without DMEM_CLEAR_ON_RESET_EN.
module tb_block_data_memory;

  localparam int LAT = 5;
  localparam int BUSY_EXP = LAT + 1;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  block_data_memory #(.LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait),
    .fsm_state (fsm_state)
  );

  // Clock / reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Start from a point just after a rising edge with the FSM in IDLE.
  // Drive one request, drop it after acceptance, and wait for DONE.
  // Then step to the next IDLE cycle.
  task automatic do_access(input logic wr, input logic [5:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int busy, output bit tmo);
    address = a; writedata = d; read = ~wr; write = wr;
    busy = 0; tmo = 1'b1;
    @(negedge clock);
    if (busywait) busy++;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (busywait) busy++;
      else begin
        tmo = 1'b0;
        break;
      end
    end
    rd = readdata;
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset(input int edges);
    reset = 1'b0; read = 1'b0; write = 1'b0;
    repeat (edges) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  logic [31:0] rd;
  int          busy;
  bit          tmo;
  logic [31:0] prior_10;
  logic [31:0] fill_exp;

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = 6'd0; writedata = 32'd0;

    // Reset state, sampled while reset is still low.
    @(posedge clock);
    @(negedge clock);
    chk("reset_busywait", {31'd0, busywait}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clock); #1 reset = 1'b1;

    // Vector table {wr, addr, data, readdata expected after the access}.
    vecs[0]  = '{1'b1, 6'h2A, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 6'h01, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 6'h3F, 32'h0BADC0DE, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 6'h01, 32'h0,        32'hCAFEF00D};
    vecs[5]  = '{1'b0, 6'h3F, 32'h0,        32'h0BADC0DE};
    vecs[6]  = '{1'b1, 6'h10, 32'h87654321, 32'h0BADC0DE};
    vecs[7]  = '{1'b0, 6'h10, 32'h0,        32'h87654321};
    vecs[8]  = '{1'b1, 6'h2A, 32'h00000000, 32'h87654321};
    vecs[9]  = '{1'b0, 6'h2A, 32'h0,        32'h00000000};
    vecs[10] = '{1'b1, 6'h05, 32'h55AA55AA, 32'h00000000};
    vecs[11] = '{1'b0, 6'h3F, 32'h0,        32'h0BADC0DE};

    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, busy, tmo);
      if (tmo) begin
        errors++; checks++;
        $display("FAIL vec%0d_timeout busywait never dropped", i);
      end
      chk($sformatf("vec%0d_busy_cycles", i), busy, BUSY_EXP);
      chk($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
    end

    // Request churn: the inputs change during ACCESS, including a write strobe.
    address = 6'h01; read = 1'b1; write = 1'b0;
    @(posedge clock); #1;
    address = 6'h3F; writedata = 32'hFFFFFFFF; read = 1'b0; write = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    write = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!busywait) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("churn_timeout", {31'd0, tmo}, 32'd0);
    chk("churn_readdata", readdata, 32'hCAFEF00D);
    @(posedge clock); #1;
    do_access(1'b0, 6'h3F, 32'h0, rd, busy, tmo);
    chk("churn_3f_untouched", rd, 32'h0BADC0DE);

    // Illegal request: read and write both high for 10 cycles.
    address = 6'h10; writedata = 32'hFFFFFFFF; read = 1'b1; write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk($sformatf("illegal_busy_c%0d", c), {31'd0, busywait}, 32'd0);
      chk($sformatf("illegal_rd_c%0d", c), readdata, 32'h0BADC0DE);
      @(posedge clock); #1;
    end
    read = 1'b0; write = 1'b0;
    do_access(1'b0, 6'h10, 32'h0, rd, busy, tmo);
    chk("illegal_array_kept", rd, 32'h87654321);

    // Back-to-back: read stays high through DONE.
    address = 6'h05; read = 1'b1; write = 1'b0;
    busy = 0; tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (busywait) busy++;
      else begin
        tmo = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    chk("b2b_first_timeout", {31'd0, tmo}, 32'd0);
    chk("b2b_first_busy", busy, BUSY_EXP);
    chk("b2b_first_rd", readdata, 32'h55AA55AA);
    chk("b2b_done_state", {30'd0, fsm_state}, 32'd2);
    @(posedge clock); #1;
    address = 6'h01;
    @(negedge clock);
    chk("b2b_idle_state", {30'd0, fsm_state}, 32'd0);
    chk("b2b_idle_busy", {31'd0, busywait}, 32'd1);
    @(posedge clock); #1;
    read = 1'b0;
    busy = 1; tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (busywait) busy++;
      else begin
        tmo = 1'b0;
        break;
      end
    end
    chk("b2b_second_timeout", {31'd0, tmo}, 32'd0);
    chk("b2b_second_busy", busy, BUSY_EXP);
    chk("b2b_second_rd", readdata, 32'hCAFEF00D);
    @(posedge clock); #1;

    // Reset abort: the write is cut by reset in its 3rd ACCESS cycle.
`ifdef DMEM_CLEAR_ON_RESET_EN
    prior_10 = 32'h0;
`else
    prior_10 = 32'h87654321;
`endif
    address = 6'h10; writedata = 32'h12345678; write = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    write = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busywait", {31'd0, busywait}, 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    chk("abort_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clock); #1;
    do_access(1'b0, 6'h10, 32'h0, rd, busy, tmo);
    chk("abort_busy", busy, BUSY_EXP);
    chk("abort_prior_value", rd, prior_10);

    // Fill every block, pulse reset, then read back the first and last block.
    for (int a = 0; a < 64; a++) begin
      do_access(1'b1, 6'(a), 32'hA5A5A5A5, rd, busy, tmo);
      if (tmo) begin
        errors++; checks++;
        $display("FAIL fill%0d_timeout busywait never dropped", a);
      end
    end
    pulse_reset(1);
`ifdef DMEM_CLEAR_ON_RESET_EN
    fill_exp = 32'h0;
`else
    fill_exp = 32'hA5A5A5A5;
`endif
    do_access(1'b0, 6'h00, 32'h0, rd, busy, tmo);
    chk("macro_blk00", rd, fill_exp);
    do_access(1'b0, 6'h3F, 32'h0, rd, busy, tmo);
    chk("macro_blk3f", rd, fill_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
